// File: rtl/signed_result_display.sv
// Output stage after the twos-complement converter: accepts a 4-bit signed result,
// converts it to sign + magnitude and multiplexes it onto a 2-digit 7-segment display.
module signed_result_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [6:0]       seg,
  output logic [1:0]       an,
  output logic             sign_led
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_next;
  logic             sign_q;
  logic [CW-1:0]    cnt;
  logic             dsel;
  logic             xfer;

  function automatic logic [6:0] glyph(input logic [WIDTH-1:0] m);
    case (m)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      default: glyph = 7'h7F;
    endcase
  endfunction

  assign in_ready = (state != CONV);
  assign xfer     = in_valid & in_ready;

  // -8 negates to 4'b1000, read back as unsigned magnitude 8
  always_comb begin
    mag_next = data_q;
    if (data_q[WIDTH-1])
      mag_next = ~data_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      cnt      <= '0;
      dsel     <= 1'b0;
      seg      <= 7'h7F;
      an       <= 2'b11;
      sign_led <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            data_q <= in_data;
            state  <= CONV;
          end
        end
        CONV: begin
          sign_q   <= data_q[WIDTH-1];
          mag_q    <= mag_next;
          sign_led <= data_q[WIDTH-1];
          cnt      <= '0;
          dsel     <= 1'b0;
          state    <= SHOW;
        end
        SHOW: begin
          // a new transfer pre-empts the refresh step; CONV restarts the mux
          if (xfer) begin
            data_q <= in_data;
            state  <= CONV;
          end else begin
            if (cnt == CNT_LAST) begin
              cnt  <= '0;
              dsel <= ~dsel;
            end else begin
              cnt <= cnt + CW'(1);
            end
            if (!dsel) begin
              an  <= 2'b10;
              seg <= glyph(mag_q);
            end else begin
              an  <= 2'b01;
              seg <= sign_q ? 7'h3F : 7'h7F;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
